// File: rtl/seq_codigo_3b.sv
// 3-bit up/down code source for the seven-segment decoder, stepped by a debounced button.
// Optional auto-step prescaler is compiled in with `define AUTO_STEP_EN.
module seq_codigo_3b #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic dir_up,
  input  logic hold,
  input  logic auto_en,
  output logic A,
  output logic B,
  output logic C,
  output logic step_pulse,
  output logic btn_db
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    CODE_0, CODE_1, CODE_2, CODE_3, CODE_4, CODE_5, CODE_6, CODE_7
  } code_t;

  code_t         code_q, code_d;
  logic          step_d;
  logic          s1, s2;
  logic [DW-1:0] deb_cnt;
  logic          press;
  logic          auto_tick;
  logic          req;

  // Two-flop synchronizer followed by a stability-count debouncer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb_cnt <= '0;
      btn_db  <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Fires on the same edge that btn_db rises; releases are not events.
  assign press = s2 && !btn_db && (deb_cnt == DEB_LAST);

`ifdef AUTO_STEP_EN
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n || !auto_en) begin
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign auto_tick = auto_en && (presc == TICK_LAST);
`else
  logic unused_auto;
  assign unused_auto = auto_en ^ (TICK_DIV == 0);
  assign auto_tick   = 1'b0;
`endif

  // A coincident press and tick collapse into a single request.
  assign req = press | auto_tick;

  always_comb begin
    code_d = code_q;
    step_d = 1'b0;
    if (req && !hold) begin
      step_d = 1'b1;
      if (dir_up) code_d = code_t'(code_q + 3'd1);
      else        code_d = code_t'(code_q - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q     <= CODE_0;
      step_pulse <= 1'b0;
    end else begin
      code_q     <= code_d;
      step_pulse <= step_d;
    end
  end

  assign {A, B, C} = code_q;

endmodule
